mont_host_sequencer: RTL and testbench

- Host-side initiator for the two-core Montgomery wrapper's command/BRAM/done protocol.
- Accepts three 1024-bit operands (A, B, M) on a valid/ready stream and issues the fixed command sequence READ_A, READ_B, READ_M, MULTIPLY, WRITE.
- Drives the operand halves on the BRAM data bus and collects both 512-bit results into one 1024-bit result stream.
- Used as the ARM/DMA stand-in in simulation and as the fabric-side driver when the wrapper is fed without the PS.

---
 rtl/mont_pkg.sv | 28 ++
 rtl/mont_done_handshake.sv | 76 +++++++
 rtl/mont_host_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mont_host_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery wrapper and its host-side sequencer:
// command codes, operand width and the FSM state encodings.
package mont_pkg;

  localparam int OPW = 512;

  localparam logic [2:0] CMD_READ_A1_A2 = 3'd0;
  localparam logic [2:0] CMD_READ_B1_B2 = 3'd1;
  localparam logic [2:0] CMD_READ_M1_M2 = 3'd2;
  localparam logic [2:0] CMD_MULTIPLY   = 3'd3;
  localparam logic [2:0] CMD_WRITE      = 3'd4;

  typedef logic [2:0] seq_state_t;
  localparam seq_state_t S_IDLE   = 3'd0;
  localparam seq_state_t S_LOAD   = 3'd1;
  localparam seq_state_t S_CMD    = 3'd2;
  localparam seq_state_t S_DATA   = 3'd3;
  localparam seq_state_t S_RDOUT  = 3'd4;
  localparam seq_state_t S_DONE   = 3'd5;
  localparam seq_state_t S_RESULT = 3'd6;

  typedef logic [1:0] hs_state_t;
  localparam hs_state_t HS_IDLE = 2'd0;
  localparam hs_state_t HS_WAIT = 2'd1;
  localparam hs_state_t HS_ACK  = 2'd2;
  localparam hs_state_t HS_CLR  = 2'd3;

endpackage

// File: rtl/mont_done_handshake.sv
// Done-flag handshake with the wrapper: wait for done, acknowledge for one
// cycle, then wait for the registered done flag to fall before reporting.
module mont_done_handshake
  import mont_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic start_wait,
  input  logic start_ack,
  input  logic port2_valid,
  output logic port2_read,
  output logic active,
  output logic done,
  output logic timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  hs_state_t     state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          expired;

  assign expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d = state_q;
    tmo_d   = tmo_q + TW'(1);
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      HS_IDLE: begin
        tmo_d = '0;
        if (start_ack)       state_d = HS_ACK;
        else if (start_wait) state_d = HS_WAIT;
      end
      HS_WAIT: begin
        if (port2_valid) state_d = HS_ACK;
        else if (expired) begin
          timeout = 1'b1;
          state_d = HS_IDLE;
        end
      end
      HS_ACK: state_d = HS_CLR;
      HS_CLR: begin
        // The wrapper's done flag lags the acknowledge; only its fall ends the step.
        if (!port2_valid) begin
          done    = 1'b1;
          state_d = HS_IDLE;
        end else if (expired) begin
          timeout = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
    if (state_d != state_q) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= HS_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  assign port2_read = (state_q == HS_ACK);
  assign active     = (state_q != HS_IDLE);

endmodule

// File: rtl/mont_host_sequencer.sv
// Host-side initiator: loads A, B, M into the two-core wrapper, runs MULTIPLY,
// reads both result halves back and presents them as one 1024-bit result.
module mont_host_sequencer
  import mont_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1023:0] op_data,
  input  logic          op_valid,
  output logic          op_ready,
  output logic [1023:0] res_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          err,
  output logic [31:0]   port1_din,
  output logic          port1_valid,
  input  logic          port1_read,
  output logic [511:0]  bram_din1,
  output logic [511:0]  bram_din2,
  output logic          bram_din_valid,
  input  logic [511:0]  bram_dout1,
  input  logic [511:0]  bram_dout2,
  input  logic          bram_dout1_valid,
  input  logic          bram_dout2_valid,
  output logic          bram_dout_read,
  input  logic          port2_valid,
  output logic          port2_read
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t    state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [1023:0] operand_q, operand_d;
  logic [1023:0] res_q, res_d;
  logic          err_q, err_d;
  logic          rd_ack_q, rd_ack_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          expired, abort, hs_wait, hs_ack, hs_done, hs_timeout, hs_active;

  assign expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  mont_done_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_done_hs (
    .clk        (clk),
    .reset      (reset),
    .start_wait (hs_wait),
    .start_ack  (hs_ack),
    .port2_valid(port2_valid),
    .port2_read (port2_read),
    .active     (hs_active),
    .done       (hs_done),
    .timeout    (hs_timeout)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    operand_d = operand_q;
    res_d     = res_q;
    err_d     = err_q;
    rd_ack_d  = 1'b0;
    tmo_d     = tmo_q + TW'(1);
    abort     = 1'b0;
    hs_wait   = 1'b0;
    hs_ack    = 1'b0;
    case (state_q)
      S_IDLE: if (op_valid) state_d = S_LOAD;
      S_LOAD: begin
        if (op_valid) begin
          operand_d = op_data;
          state_d   = S_CMD;
          if (step_q == CMD_READ_A1_A2) err_d = 1'b0;
        end
      end
      S_CMD: begin
        // A handshake in the expiry cycle still counts.
        if (port1_read) begin
          if (step_q == CMD_MULTIPLY) begin
            state_d = S_DONE;
            hs_wait = 1'b1;
          end else if (step_q == CMD_WRITE) begin
            state_d = S_RDOUT;
          end else begin
            state_d = S_DATA;
          end
        end else if (expired) abort = 1'b1;
      end
      S_DATA: begin
        if (port2_valid) begin
          state_d = S_DONE;
          hs_ack  = 1'b1;
        end else if (expired) abort = 1'b1;
      end
      S_RDOUT: begin
        if (bram_dout1_valid && bram_dout2_valid) begin
          res_d    = {bram_dout2, bram_dout1};
          rd_ack_d = 1'b1;
          state_d  = S_DONE;
          hs_wait  = 1'b1;
        end else if (expired) abort = 1'b1;
      end
      S_DONE: begin
        if (hs_done) begin
          if (step_q == CMD_WRITE) begin
            state_d = S_RESULT;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = (step_q < CMD_READ_M1_M2) ? S_LOAD : S_CMD;
          end
        end else if (hs_timeout || !hs_active) abort = 1'b1;
      end
      S_RESULT: begin
        if (res_ready) begin
          step_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      err_d   = 1'b1;
      step_d  = '0;
      res_d   = '0;
      state_d = S_IDLE;
    end
    if (state_d != state_q || !(state_q inside {S_CMD, S_DATA, S_RDOUT})) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide operand/result registers are reset too, so res_data reads 0 after reset.
      state_q   <= S_IDLE;
      step_q    <= '0;
      operand_q <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      operand_q <= operand_d;
      res_q     <= res_d;
      err_q     <= err_d;
      rd_ack_q  <= rd_ack_d;
      tmo_q     <= tmo_d;
    end
  end

  assign op_ready       = (state_q == S_LOAD);
  assign port1_valid    = (state_q == S_CMD);
  assign port1_din      = port1_valid ? {29'd0, step_q} : 32'd0;
  assign bram_din_valid = (state_q == S_DATA);
  assign bram_din1      = bram_din_valid ? operand_q[511:0] : 512'd0;
  assign bram_din2      = bram_din_valid ? operand_q[1023:512] : 512'd0;
  assign bram_dout_read = rd_ack_q;
  assign res_data       = res_q;
  assign res_valid      = (state_q == S_RESULT);
  assign busy           = (state_q != S_IDLE);
  assign err            = err_q;

endmodule

// File: tb/tb_mont_host_sequencer.sv
// Randomized bench for mont_host_sequencer: a behavioural wrapper responder
// plus a job-level reference model of commands, operand traffic and results.
module tb_mont_host_sequencer;

  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1023:0] op_data;
  logic          op_valid;
  logic          op_ready;
  logic [1023:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          err;
  logic [31:0]   port1_din;
  logic          port1_valid;
  logic          port1_read;
  logic [511:0]  bram_din1, bram_din2;
  logic          bram_din_valid;
  logic [511:0]  bram_dout1, bram_dout2;
  logic          bram_dout1_valid, bram_dout2_valid;
  logic          bram_dout_read;
  logic          port2_valid;
  logic          port2_read;

  int checks = 0;
  int errors = 0;

  // Responder (wrapper stand-in) controls and logs
  bit            hang = 0;
  bit            hold_din = 0;
  bit            fixed_res = 0;
  int            extra_stale = 0;
  int            rs = 0;
  int            code = 0;
  int            dly = 0;
  int            stale = 0;
  logic [1023:0] ra = '0, rb = '0, rm = '0;
  int            cmd_log[$];
  logic [1023:0] din_log[$];
  int            p2r_cnt = 0;
  int            dr_cnt = 0;
  int            stale_viol = 0;

  mont_host_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .op_data         (op_data),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .res_data        (res_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .busy            (busy),
    .err             (err),
    .port1_din       (port1_din),
    .port1_valid     (port1_valid),
    .port1_read      (port1_read),
    .bram_din1       (bram_din1),
    .bram_din2       (bram_din2),
    .bram_din_valid  (bram_din_valid),
    .bram_dout1      (bram_dout1),
    .bram_dout2      (bram_dout2),
    .bram_dout1_valid(bram_dout1_valid),
    .bram_dout2_valid(bram_dout2_valid),
    .bram_dout_read  (bram_dout_read),
    .port2_valid     (port2_valid),
    .port2_read      (port2_read)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h..%h exp=%h..%h", tag, got[1023:928], got[95:0],
               exp[1023:928], exp[95:0]);
    end
  endtask

  // Stand-in for the wrapper's arithmetic: per core, (a ^ b) + m mod 2^512.
  function automatic logic [1023:0] model_res(input logic [1023:0] a, b, m);
    logic [511:0] lo, hi;
    lo = (a[511:0] ^ b[511:0]) + m[511:0];
    hi = (a[1023:512] ^ b[1023:512]) + m[1023:512];
    return {hi, lo};
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Wrapper responder: reads a command one cycle after it appears, takes the
  // operand halves, raises done, and keeps done high for 1+extra_stale cycles
  // after the acknowledge (the wrapper's flags are registered).
  always @(negedge clk) begin
    if (reset) begin
      rs               <= 0;
      port1_read       <= 1'b0;
      port2_valid      <= 1'b0;
      bram_dout1_valid <= 1'b0;
      bram_dout2_valid <= 1'b0;
      bram_dout1       <= '0;
      bram_dout2       <= '0;
    end else begin
      if (bram_dout_read) begin
        bram_dout1_valid <= 1'b0;
        bram_dout2_valid <= 1'b0;
        dr_cnt           <= dr_cnt + 1;
      end
      if (port2_read) p2r_cnt <= p2r_cnt + 1;
      if ((port1_valid || op_ready) && port2_valid) stale_viol <= stale_viol + 1;
      case (rs)
        0: if (port1_valid && !hang) begin
             code <= int'(port1_din);
             cmd_log.push_back(int'(port1_din));
             dly  <= $urandom_range(0, 6);
             rs   <= 1;
           end
        1: begin port1_read <= 1'b1; rs <= 2; end
        2: begin port1_read <= 1'b0; rs <= 3; end
        3: begin
          if (code <= 2) begin
            if (bram_din_valid && !hold_din) begin
              din_log.push_back({bram_din2, bram_din1});
              if (code == 0) ra <= {bram_din2, bram_din1};
              else if (code == 1) rb <= {bram_din2, bram_din1};
              else rm <= {bram_din2, bram_din1};
              port2_valid <= 1'b1;
              rs <= 4;
            end
          end else if (dly > 0) begin
            dly <= dly - 1;
          end else begin
            port2_valid <= 1'b1;
            if (code == 4) begin
              logic [1023:0] r;
              r = fixed_res ? {512'hBB, 512'hAA} : model_res(ra, rb, rm);
              bram_dout1       <= r[511:0];
              bram_dout2       <= r[1023:512];
              bram_dout1_valid <= 1'b1;
              bram_dout2_valid <= 1'b1;
            end
            rs <= 4;
          end
        end
        4: if (port2_read) begin stale <= 1 + extra_stale; rs <= 5; end
        default: begin
          if (stale <= 1) begin port2_valid <= 1'b0; rs <= 0; end
          else stale <= stale - 1;
        end
      endcase
    end
  end

  task automatic send_op(input logic [1023:0] d, input int gap, output bit ok, output int waited);
    int bad, n;
    ok = 0;
    waited = 0;
    if (gap > 0) begin
      for (int i = 0; i < 200 && !op_ready; i++) @(negedge clk);
      n = cmd_log.size();
      bad = 0;
      repeat (gap) begin
        @(negedge clk);
        if (port1_valid || !op_ready) bad++;
      end
      check("load_stall", bad + (cmd_log.size() - n), 0);
      op_data  = d;
      op_valid = 1'b1;
      ok = op_ready;
    end else begin
      op_data  = d;
      op_valid = 1'b1;
    end
    while (!ok && waited < 200) begin
      @(negedge clk);
      waited++;
      ok = op_ready;
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic get_res(input int hold, output logic [1023:0] r, output bit ok);
    int unstable;
    ok = 0;
    r  = '0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = res_valid;
    end
    if (!ok) return;
    r = res_data;
    unstable = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!res_valid || res_data !== r) unstable++;
    end
    if (hold > 0) check("res_hold_stable", unstable, 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic run_job(input logic [1023:0] a, b, m, input int gap, input int hold,
                         output int first_wait);
    logic [1023:0] ops[3];
    logic [1023:0] exp_res, got;
    bit ok;
    int w, p2r0, dr0, sv0, enc, exp_enc;
    ops[0] = a; ops[1] = b; ops[2] = m;
    cmd_log.delete();
    din_log.delete();
    p2r0 = p2r_cnt; dr0 = dr_cnt; sv0 = stale_viol;
    exp_res = fixed_res ? {512'hBB, 512'hAA} : model_res(a, b, m);
    first_wait = 0;
    for (int k = 0; k < 3; k++) begin
      send_op(ops[k], (k == 0) ? 0 : gap, ok, w);
      check($sformatf("op%0d_accept", k), ok, 1);
      if (k == 0) begin
        first_wait = w;
        check("err_clear", err, 0);
      end
    end
    get_res(hold, got, ok);
    check("res_seen", ok, 1);
    check("res_data", got, exp_res);
    check("busy_after", busy, 0);
    check("err_after", err, 0);
    enc = 0;
    foreach (cmd_log[i]) enc = enc * 8 + cmd_log[i];
    exp_enc = 0;
    for (int k = 0; k < 5; k++) exp_enc = exp_enc * 8 + k;
    check("cmd_count", cmd_log.size(), 5);
    check("cmd_order", enc, exp_enc);
    check("din_count", din_log.size(), 3);
    for (int k = 0; k < 3 && k < din_log.size(); k++) check($sformatf("din%0d", k), din_log[k], ops[k]);
    check("port2_read_count", p2r_cnt - p2r0, 5);
    check("dout_read_count", dr_cnt - dr0, 1);
    check("stale_done", stale_viol - sv0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int w, n;
    bit ok, seen;
    reset = 1'b1; op_valid = 1'b0; op_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {op_ready, res_valid, busy, err, port1_valid, bram_din_valid,
                       bram_dout_read, port2_read}, 0);
    check("rst_res_data", res_data, 0);
    check("rst_port1_din", port1_din, 0);
    #1 reset = 1'b0;

    // Full sequence with fixed operands and fixed result halves
    fixed_res = 1;
    run_job(1024'h3, 1024'h5, 1024'h7, 0, 0, w);
    fixed_res = 0;

    // Stale done held three extra cycles
    extra_stale = 3;
    run_job(rand1024(), rand1024(), rand1024(), 0, 0, w);
    extra_stale = 0;

    // Operand and result backpressure
    run_job(rand1024(), rand1024(), rand1024(), 20, 10, w);

    // Timeout: responder never reads the command
    hang = 1;
    send_op(rand1024(), 0, ok, w);
    check("tmo_opA_accept", ok, 1);
    n = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (port1_valid) n++;
      else seen = 1;
    end
    check("tmo_cmd_cycles", n, TMO);
    check("tmo_err", err, 1);
    check("tmo_idle", {busy, port1_valid, op_ready}, 0);
    hang = 0;
    run_job(rand1024(), rand1024(), rand1024(), 0, 0, w);

    // Reset while operand halves are on the bus
    hold_din = 1;
    send_op(rand1024(), 0, ok, w);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bram_din_valid;
    end
    check("rdata_reached", seen, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ctrl", {op_ready, res_valid, busy, err, port1_valid, bram_din_valid,
                           bram_dout_read, port2_read}, 0);
    check("mid_rst_din", {bram_din2, bram_din1}, 0);
    check("mid_rst_res", res_data, 0);
    #1 reset = 1'b0;
    hold_din = 0;
    run_job(rand1024(), rand1024(), rand1024(), 0, 0, w);

    // Back-to-back jobs: op_ready returns in the LOAD cycle after the IDLE cycle
    run_job(rand1024(), rand1024(), rand1024(), 0, 0, w);
    run_job(rand1024(), rand1024(), rand1024(), 0, 0, w);
    check("b2b_op_ready_lat", w, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
